// File: rtl/id_fetch_queue.sv
// Fetch-to-decode instruction queue: registered FIFO of {pc, instr} entries.
// An empty queue presents a NOP at pc 0 so decode only ever sees a bubble.
module id_fetch_queue #(
   parameter int unsigned     DEPTH     = 4,
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [XLEN-1:0]            in_pc_i,
   input  logic [XLEN-1:0]            in_instr_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [XLEN-1:0]            out_pc_o,
   output logic [XLEN-1:0]            out_instr_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == CW'(DEPTH));
   assign count_o     = count_q;
   assign in_ready_o  = !full_o;
   assign out_valid_o = !empty_o;

   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is deliberately unreset; the empty mux hides stale words.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= in_pc_i;
         instr_mem[wr_ptr_q] <= in_instr_i;
      end
   end

   assign out_pc_o    = empty_o ? '0 : pc_mem[rd_ptr_q];
   assign out_instr_o = empty_o ? NOP_INSTR : instr_mem[rd_ptr_q];

endmodule

// File: tb/tb_id_fetch_queue.sv
// Directed bench for id_fetch_queue: ordering, full/empty bounds,
// steady-state wrap, flush priority and async reset.
module tb_id_fetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;
   logic        empty;
   logic        full;

   int n_chk;
   int n_fail;

   id_fetch_queue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_pc_i     (in_pc),
      .in_instr_i  (in_instr),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_pc_o    (out_pc),
      .out_instr_o (out_instr),
      .count_o     (count),
      .empty_o     (empty),
      .full_o      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A stalled offer must keep its payload until it is taken or withdrawn.
   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready) |=> (!in_valid || ($stable(in_pc) && $stable(in_instr))));

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return pc ^ 32'h00A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = ins(pc);
   endtask

   task automatic head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_instr"}, out_instr, ins(pc));
   endtask

   task automatic idle_out(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_pc"}, out_pc, 32'd0);
      chk({tag, "_instr"}, out_instr, NOP);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      tick();
      tick();
      idle_out("rst");
      chk("rst_full", 32'(full), 32'd0);
      rst_n = 1'b1;
      tick();

      // Three pushes while decode stalls, then drain in order.
      offer(32'h100);
      #1 chk("nobypass_valid", 32'(out_valid), 32'd0);
      tick();
      head("first", 32'h100);
      offer(32'h104);
      tick();
      offer(32'h108);
      tick();
      in_valid = 1'b0;
      chk("three_count", 32'(count), 32'd3);
      tick();
      head("held", 32'h100);
      out_ready = 1'b1;
      tick();
      head("drain1", 32'h104);
      tick();
      head("drain2", 32'h108);
      tick();
      idle_out("drained");

      // Fill to DEPTH, refuse the fifth offer, free one slot.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(32'h300 + 32'(4 * i));
         tick();
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_count", 32'(count), 32'd4);
      offer(32'h310);
      tick();
      chk("refused_count", 32'(count), 32'd4);
      head("refused_head", 32'h300);
      out_ready = 1'b1;
      tick();
      chk("popfull_count", 32'(count), 32'd3);
      chk("popfull_in_ready", 32'(in_ready), 32'd1);
      head("popfull_head", 32'h304);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("refill_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         head("fill_drain", 32'h304 + 32'(4 * i));
         tick();
      end
      idle_out("fill_empty");

      // Steady push+pop at count 2 across several pointer wraps.
      out_ready = 1'b0;
      offer(32'h400);
      tick();
      offer(32'h404);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         offer(32'h408 + 32'(4 * i));
         head("wrap_head", 32'h400 + 32'(4 * i));
         tick();
         chk("wrap_count", 32'(count), 32'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      head("wrap_final", 32'h428);

      // Flush beats a same-edge push and pop.
      offer(32'h500);
      tick();
      chk("preflush_count", 32'(count), 32'd3);
      flush     = 1'b1;
      out_ready = 1'b1;
      offer(32'h504);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      idle_out("flush");
      tick();
      idle_out("flush_after");

      // Async reset in the middle of a cycle.
      out_ready = 1'b0;
      offer(32'h600);
      tick();
      offer(32'h604);
      tick();
      in_valid = 1'b0;
      chk("prerst_count", 32'(count), 32'd2);
      #2 rst_n = 1'b0;
      #1 idle_out("async_rst");
      tick();
      rst_n = 1'b1;
      offer(32'h200);
      #1 chk("postrst_nobypass", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      head("postrst", 32'h200);
      chk("postrst_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      tick();

      // Pop requests on an empty queue do nothing.
      for (int i = 0; i < 5; i++) begin
         tick();
         idle_out("underflow");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
